absmax_reduce_ctrl: RTL and testbench
=====================================

# absmax_reduce_ctrl

Streaming max-|x| reduction sequencer built around the shared segmented `abs_comparator` in the FP utilities. It accepts a packet of 32-bit `fp_vec_u` words, one per cycle. It keeps a running largest-magnitude element per lane: two independent lanes in FP16x2, one 32-bit lane in FP32. After the last beat it presents the winning element(s) and their in-packet indices through a valid/ready result port. It sits between an operand stream source (vector load or reduction unit) and the consumer of norm/scale results.

## Interface
- `IDX_W`, default 16: width of the element index counters and index outputs.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  `fp_vec_u`  operand word (`lanes.hi`, `lanes.lo`).
- `in_fmt`  in  `fp_fmt_e`  packet format; sampled on the first beat only.
- `in_last`  in  1  marks the final beat of the packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  `fp_vec_u`  winning element per lane, with original sign bits preserved.
- `out_idx_hi`  out  `IDX_W`  beat index of the `lanes.hi` winner (the whole-word winner in FP32).
- `out_idx_lo`  out  `IDX_W`  beat index of the `lanes.lo` winner; equals `out_idx_hi` in FP32.
- `out_fmt`  out  `fp_fmt_e`  format latched for this packet.
- `busy`  out  1  a packet is in progress or a result is pending (`state != IDLE`).

## Operation
- States are IDLE, ACC and DONE. A beat is accepted when `in_valid & in_ready`. `in_ready = (state != DONE)`.
- IDLE, beat accepted:
  - Load `acc <= in_data`, `idx_hi/idx_lo <= 0`, `fmt_q <= in_fmt`, `cnt <= 1`.
  - If `in_last`, go to DONE; otherwise go to ACC.
- ACC, beat accepted:
  - One `abs_comparator` instance is driven with `fmt = fmt_q`, `x = acc`, `y = in_data`. `swap_h`/`swap_l` therefore mean that the incoming magnitude is strictly greater.
  - FP16x2: if `swap_h`, then `acc.hi <= in.hi` and `idx_hi <= cnt`. Independently, if `swap_l`, then `acc.lo <= in.lo` and `idx_lo <= cnt`.
  - FP32 (any `fmt_q != FP16`): if `swap_h`, replace the whole word and set both indices to `cnt`. `swap_l` is ignored.
  - `cnt` increments and saturates at `2^IDX_W - 1`.
  - If `in_last`, go to DONE.
- DONE:
  - `out_valid = 1`; `out_data`, `out_idx_*` and `out_fmt` are the registered `acc`, `idx` and `fmt_q`.
  - On `out_ready`, go to IDLE.
- Magnitude comparison is raw-bit unsigned with the sign masked. Ties keep the earlier element (lowest index). NaN/Inf are ordered by bit pattern, so a NaN beats any finite value; no special-casing.
- `in_fmt` on non-first beats is ignored. Changing format mid-packet is not an error.
- No beat is accepted while in DONE. The next packet's first beat is accepted at the earliest in the cycle after the result handshake (one bubble).

## Timing
- Throughput is 1 beat/cycle in IDLE/ACC. The comparator is combinational inside the cycle, and the registers update on the accepting edge.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, i.e. it is visible the cycle after that beat is presented.
- `out_valid` is held with stable `out_data`, `out_idx_*` and `out_fmt` until `out_ready`. It drops the cycle after the handshake.
- Reset values:
  - state IDLE, so `in_ready = 1`, `out_valid = 0`, `busy = 0`.
  - `out_data = 0`, `out_idx_hi = out_idx_lo = 0`, `out_fmt = FP32`, `cnt = 0`.
- Reset asserted mid-packet or in DONE clears all state immediately and asynchronously. The partial or pending result is discarded and no output pulse is emitted.
- `in_valid` while in DONE is not accepted. The source must hold its beat.

## Test plan
- FP32 packet `0x3F800000`, `0xC0400000`, `0x40000000` (last) -> `out_data = 0xC0400000`, `out_idx_hi = out_idx_lo = 1`, `out_fmt = FP32`, `out_valid` the cycle after the last beat.
- FP16x2 packet {hi,lo}: {`0x3C00`,`0xC000`}, {`0xC200`,`0x3C00`}, {`0x4000`,`0x4000`} (last) -> `out_data = {0xC200, 0xC000}`, `out_idx_hi = 1`, `out_idx_lo = 0`. This checks the lo-lane tie keeping the earlier element and that no lo-to-hi carry leaks.
- Single-beat packet `0x7FC00000` with `in_last = 1` in IDLE -> DONE next cycle, `out_data = 0x7FC00000`, both indices 0.
- Backpressure: hold `out_ready = 0` for 5 cycles in DONE -> `out_valid = 1`, outputs stable, `in_ready = 0`, offered beat not consumed. Pulse `out_ready` -> `in_ready = 1` next cycle and the held beat is accepted as index 0 of a new packet.
- Assert `rst_n = 0` after beat 2 of a 4-beat FP32 packet -> all outputs at reset values immediately. A new packet `0xBF800000` (last) -> `out_data = 0xBF800000`, idx 0.
- FP16 packet whose beat 1 carries `in_fmt = FP32` -> per-lane results still computed as FP16x2.

Source files
------------

// File: rtl/absmax_reduce_ctrl.sv
// rtl/absmax_reduce_ctrl.sv - streaming per-lane max-|x| reduction with index tracking
// Holds the FP types, the segmented magnitude comparator and the reduction sequencer.

package absmax_pkg;
  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    BF16 = 2'd2
  } fp_fmt_e;

  typedef union packed {
    logic [31:0] word;
    struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
    } lanes;
  } fp_vec_u;
endpackage

module abs_comparator
  import absmax_pkg::*;
(
  input  fp_fmt_e fmt,
  input  fp_vec_u x,
  input  fp_vec_u y,
  output logic    swap_h,
  output logic    swap_l
);
  logic [31:0] mask;
  logic [31:0] xm;
  logic [31:0] ym;

  // Sign bits are masked so the raw-bit unsigned compare orders by magnitude.
  always_comb begin
    mask   = (fmt == FP16) ? 32'h7FFF_7FFF : 32'h7FFF_FFFF;
    xm     = x.word & mask;
    ym     = y.word & mask;
    swap_h = 1'b0;
    swap_l = 1'b0;
    if (fmt == FP16) begin
      swap_h = ym[31:16] > xm[31:16];
      swap_l = ym[15:0] > xm[15:0];
    end else begin
      swap_h = ym > xm;
    end
  end
endmodule

module absmax_reduce_ctrl
  import absmax_pkg::*;
#(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_vec_u          in_data,
  input  fp_fmt_e          in_fmt,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_vec_u          out_data,
  output logic [IDX_W-1:0] out_idx_hi,
  output logic [IDX_W-1:0] out_idx_lo,
  output fp_fmt_e          out_fmt,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nxt;
  fp_vec_u          acc;
  fp_fmt_e          fmt_q;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             swap_h;
  logic             swap_l;

  abs_comparator u_cmp (
    .fmt    (fmt_q),
    .x      (acc),
    .y      (in_data),
    .swap_h (swap_h),
    .swap_l (swap_l)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_nxt = in_last ? DONE : ACC;
      end
      ACC: begin
        accept = in_valid;
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      fmt_q  <= FP32;
      idx_hi <= '0;
      idx_lo <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc    <= in_data;
        fmt_q  <= in_fmt;
        idx_hi <= '0;
        idx_lo <= '0;
        cnt    <= {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        if (fmt_q == FP16) begin
          if (swap_h) begin
            acc.lanes.hi <= in_data.lanes.hi;
            idx_hi       <= cnt;
          end
          if (swap_l) begin
            acc.lanes.lo <= in_data.lanes.lo;
            idx_lo       <= cnt;
          end
        end else if (swap_h) begin
          acc    <= in_data;
          idx_hi <= cnt;
          idx_lo <= cnt;
        end
        if (cnt != {IDX_W{1'b1}}) cnt <= cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_data   = acc;
  assign out_idx_hi = idx_hi;
  assign out_idx_lo = idx_lo;
  assign out_fmt    = fmt_q;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_absmax_reduce_ctrl.sv
// tb/tb_absmax_reduce_ctrl.sv - directed-vector bench for absmax_reduce_ctrl
module tb_absmax_reduce_ctrl;
  import absmax_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  fp_vec_u     in_data;
  fp_fmt_e     in_fmt;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  fp_vec_u     out_data;
  logic [15:0] out_idx_hi;
  logic [15:0] out_idx_lo;
  fp_fmt_e     out_fmt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  absmax_reduce_ctrl #(.IDX_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_fmt     (in_fmt),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx_hi (out_idx_hi),
    .out_idx_lo (out_idx_lo),
    .out_fmt    (out_fmt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; presents one beat across the next edge.
  task automatic beat(input logic [31:0] d, input fp_fmt_e f, input logic l);
    in_valid     = 1'b1;
    in_data.word = d;
    in_fmt       = f;
    in_last      = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] d, input logic [15:0] ih,
                              input logic [15:0] il, input fp_fmt_e f);
    check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, ".data"}, {32'd0, out_data.word}, {32'd0, d});
    check({tag, ".idx_hi"}, {48'd0, out_idx_hi}, {48'd0, ih});
    check({tag, ".idx_lo"}, {48'd0, out_idx_lo}, {48'd0, il});
    check({tag, ".fmt"}, {62'd0, out_fmt}, {62'd0, f});
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, ".busy"}, {63'd0, busy}, 64'd0);
    check({tag, ".data"}, {32'd0, out_data.word}, 64'd0);
    check({tag, ".idx_hi"}, {48'd0, out_idx_hi}, 64'd0);
    check({tag, ".idx_lo"}, {48'd0, out_idx_lo}, 64'd0);
    check({tag, ".fmt"}, {62'd0, out_fmt}, {62'd0, FP32});
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data.word = 32'd0;
    in_fmt       = FP32;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FP32 three-beat packet
    beat(32'h3F80_0000, FP32, 1'b0);
    check("fp32.busy", {63'd0, busy}, 64'd1);
    check("fp32.no_early_valid", {63'd0, out_valid}, 64'd0);
    beat(32'hC040_0000, FP32, 1'b0);
    check("fp32.no_valid_mid", {63'd0, out_valid}, 64'd0);
    beat(32'h4000_0000, FP32, 1'b1);
    check_result("fp32", 32'hC040_0000, 16'd1, 16'd1, FP32);
    take_result("fp32");

    // FP16x2: hi winner at beat 1, lo tie keeps beat 0
    beat(32'h3C00_C000, FP16, 1'b0);
    beat(32'hC200_3C00, FP16, 1'b0);
    beat(32'h4000_4000, FP16, 1'b1);
    check_result("fp16", 32'hC200_C000, 16'd1, 16'd0, FP16);
    take_result("fp16");

    // Single-beat packet
    beat(32'h7FC0_0000, FP32, 1'b1);
    check_result("single", 32'h7FC0_0000, 16'd0, 16'd0, FP32);

    // Backpressure: result held, offered beat not taken
    in_valid     = 1'b1;
    in_data.word = 32'h4049_0FDB;
    in_fmt       = FP32;
    in_last      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.valid", {63'd0, out_valid}, 64'd1);
      check("bp.in_ready", {63'd0, in_ready}, 64'd0);
      check("bp.data", {32'd0, out_data.word}, 64'h7FC0_0000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp.bubble_ready", {63'd0, in_ready}, 64'd1);
    check("bp.bubble_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp.held", 32'h4049_0FDB, 16'd0, 16'd0, FP32);
    take_result("bp.held");

    // Reset mid-packet
    beat(32'h4100_0000, FP32, 1'b0);
    beat(32'hC200_0000, FP32, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(32'hBF80_0000, FP32, 1'b1);
    check_result("after_rst", 32'hBF80_0000, 16'd0, 16'd0, FP32);
    take_result("after_rst");

    // Format on non-first beat is ignored: stays FP16x2
    beat(32'h0001_7000, FP16, 1'b0);
    beat(32'h0002_0001, FP32, 1'b1);
    check_result("fmtlatch", 32'h0002_7000, 16'd1, 16'd0, FP16);
    take_result("fmtlatch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
